// File: rtl/mem_stage_hs_pkg.sv
// Shared types and constants for the MEM pipeline stage: load-op encoding
// and the default datapath geometry.
package mem_stage_hs_pkg;

  localparam int LD_OP_W = 3;

  typedef enum logic [LD_OP_W-1:0] {
    LD_W    = 3'b000,
    LD_B    = 3'b001,
    LD_H    = 3'b010,
    LD_BU   = 3'b011,
    LD_HU   = 3'b100,
    LD_NONE = 3'b111
  } ld_op_e;

  localparam int XLEN_DEF     = 32;
  localparam int REGIDX_DEF   = 5;
  localparam int PC_W_DEF     = 32;
  localparam int MAX_DISC_DEF = 2;

  // EX->MS bus is {mem_req, ld_op, gr_we, dest, alu_result, pc}
  function automatic int es2ms_wd(input int xlen, input int regidx, input int pc_w);
    return 1 + LD_OP_W + 1 + regidx + xlen + pc_w;
  endfunction

  // MS->WB bus is {gr_we, dest, final_result, pc}
  function automatic int ms2ws_wd(input int xlen, input int regidx, input int pc_w);
    return 1 + regidx + xlen + pc_w;
  endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Load data alignment: selects the addressed byte/halfword of a response word
// and sign- or zero-extends it to XLEN.
module mem_stage_hs_load_align
  import mem_stage_hs_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  ld_op_e            ld_op,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   raw,
  output logic [XLEN-1:0]   data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{off, 3'b000} +: 8];
    // Misaligned halfword offsets fall back to off[1]; EX has already flagged them.
    half_sel = raw[{off[1], 4'b0000} +: 16];
    data     = raw;
    case (ld_op)
      LD_B:    data = XLEN'(byte_sel);
      LD_H:    data = XLEN'(half_sel);
      LD_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      LD_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with data-SRAM request/response handshake: holds one
// instruction, waits for data_ok, buffers early responses and drops orphans.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int REGIDX   = REGIDX_DEF,
  parameter  int PC_W     = PC_W_DEF,
  parameter  int MAX_DISC = MAX_DISC_DEF,
  localparam int ES2MS_WD = es2ms_wd(XLEN, REGIDX, PC_W),
  localparam int MS2WS_WD = ms2ws_wd(XLEN, REGIDX, PC_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ws_allowin,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES2MS_WD-1:0] es_to_ms_bus,
  output logic                ms_to_ws_valid,
  output logic [MS2WS_WD-1:0] ms_to_ws_bus,
  input  logic                data_sram_data_ok,
  input  logic [XLEN-1:0]     data_sram_rdata,
  input  logic                ms_flush,
  output logic                ms_fwd_we,
  output logic [REGIDX-1:0]   ms_fwd_dest,
  output logic [XLEN-1:0]     ms_fwd_data,
  output logic                ms_fwd_stall
);

  localparam int DISC_W   = $clog2(MAX_DISC + 1);
  localparam int ALU_LSB  = PC_W;
  localparam int DEST_LSB = PC_W + XLEN;
  localparam int WE_BIT   = DEST_LSB + REGIDX;
  localparam int OP_LSB   = WE_BIT + 1;
  localparam int REQ_BIT  = OP_LSB + LD_OP_W;

  // Orphan counter step, saturating at MAX_DISC.
  function automatic logic [DISC_W-1:0] disc_step(input logic [DISC_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (inc && !dec) return (cnt == DISC_W'(MAX_DISC)) ? cnt : cnt + DISC_W'(1);
    if (dec && !inc) return cnt - DISC_W'(1);
    return cnt;
  endfunction

  logic                vld_p0;
  logic [ES2MS_WD-1:0] bus_p0;
  logic                buf_vld_p0;
  logic [XLEN-1:0]     buf_data_p0;
  logic [DISC_W-1:0]   disc_cnt;

  logic                mem_req;
  ld_op_e              ld_op;
  logic                gr_we;
  logic [REGIDX-1:0]   dest;
  logic [XLEN-1:0]     alu_result;
  logic [PC_W-1:0]     pc;

  logic                no_disc;
  logic                resp_live;
  logic                resp_to_ms;
  logic                ms_ready_go;
  logic                leave;
  logic                disc_inc;
  logic                disc_dec;
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     ld_data;
  logic [XLEN-1:0]     final_result;

  assign mem_req    = bus_p0[REQ_BIT];
  assign ld_op      = ld_op_e'(bus_p0[OP_LSB +: LD_OP_W]);
  assign gr_we      = bus_p0[WE_BIT];
  assign dest       = bus_p0[DEST_LSB +: REGIDX];
  assign alu_result = bus_p0[ALU_LSB +: XLEN];
  assign pc         = bus_p0[PC_W-1:0];

  // A response reaches MS only once every orphan ahead of it has drained.
  assign no_disc     = (disc_cnt == '0);
  assign resp_live   = data_sram_data_ok & no_disc;
  assign resp_to_ms  = resp_live & vld_p0 & mem_req & ~buf_vld_p0;
  assign ms_ready_go = ~mem_req | buf_vld_p0 | resp_live;

  assign ms_to_ws_valid = vld_p0 & ms_ready_go & ~ms_flush;
  assign ms_allowin     = ~vld_p0 | (ms_ready_go & ws_allowin);
  assign leave          = ms_to_ws_valid & ws_allowin;

  // Flushing a request whose response is still in flight leaves an orphan behind.
  assign disc_inc = ms_flush & vld_p0 & mem_req & ~buf_vld_p0 & ~resp_live;
  assign disc_dec = data_sram_data_ok & ~no_disc;

  assign raw = buf_vld_p0 ? buf_data_p0 : data_sram_rdata;

  mem_stage_hs_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .ld_op (ld_op),
    .off   (alu_result[1:0]),
    .raw   (raw),
    .data  (ld_data)
  );

  always_comb begin
    final_result = '0;
    if (vld_p0) final_result = (ld_op == LD_NONE) ? alu_result : ld_data;
  end

  // ---- EX -> MS stage boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      bus_p0 <= '0;
    end else begin
      if (ms_flush)        vld_p0 <= 1'b0;
      else if (ms_allowin) vld_p0 <= es_to_ms_valid;
      if (es_to_ms_valid & ms_allowin & ~ms_flush) bus_p0 <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld_p0 <= 1'b0;
      disc_cnt   <= '0;
    end else begin
      if (ms_flush | leave) buf_vld_p0 <= 1'b0;
      else if (resp_to_ms)  buf_vld_p0 <= 1'b1;
      disc_cnt <= disc_step(disc_cnt, disc_inc, disc_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_to_ms & ~leave & ~ms_flush) buf_data_p0 <= data_sram_rdata;
  end

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_fwd_we    = vld_p0 & gr_we;
  assign ms_fwd_dest  = vld_p0 ? dest : '0;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_stall = vld_p0 & mem_req & (ld_op != LD_NONE) & ~buf_vld_p0 & ~resp_live;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios plus randomized traffic checked
// against a transaction-level model of the stage.
module tb_mem_stage_hs;
  import mem_stage_hs_pkg::*;

  localparam int ES_W = 74;
  localparam int WS_W = 70;

  logic            clk = 1'b0;
  logic            reset;
  logic            ws_allowin, ms_allowin, es_to_ms_valid, ms_to_ws_valid;
  logic            data_ok, ms_flush, fwd_we, fwd_stall;
  logic [ES_W-1:0] es_bus;
  logic [WS_W-1:0] ws_bus;
  logic [31:0]     rdata, fwd_data, out_res, out_pc;
  logic [4:0]      fwd_dest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign out_res = ws_bus[63:32];
  assign out_pc  = ws_bus[31:0];

  mem_stage_hs dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ws_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_flush          (ms_flush),
    .ms_fwd_we         (fwd_we),
    .ms_fwd_dest       (fwd_dest),
    .ms_fwd_data       (fwd_data),
    .ms_fwd_stall      (fwd_stall)
  );

  // Reference model: the instruction held in MS, its buffered response and
  // the number of responses still owed to flushed instructions.
  logic        m_valid, m_mem, m_we, m_have;
  logic [2:0]  m_op;
  logic [4:0]  m_dest;
  logic [31:0] m_alu, m_pc, m_data;
  int          m_orph;
  logic        e_mine, e_ready, e_valid, e_allowin, e_stall;
  logic [31:0] e_result;

  function automatic logic [ES_W-1:0] mk_bus(input logic mem, input logic [2:0] op,
      input logic we, input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pcv);
    return {mem, op, we, dst, alu, pcv};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input int off, input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      3'b001:  return (b >= 32'h80)   ? b - 32'h100   : b;
      3'b010:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b011:  return b;
      3'b100:  return h;
      default: return word;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_mem = 0; m_we = 0; m_have = 0; m_op = 3'b000;
    m_dest = '0; m_alu = '0; m_pc = '0; m_data = '0; m_orph = 0;
  endtask

  task automatic model_eval();
    e_mine    = data_ok && (m_orph == 0);
    e_ready   = !m_mem || m_have || e_mine;
    e_valid   = m_valid && e_ready && !ms_flush;
    e_allowin = !m_valid || (e_ready && ws_allowin);
    e_stall   = m_valid && m_mem && (m_op != 3'b111) && !m_have && !e_mine;
    if (!m_valid)            e_result = '0;
    else if (m_op == 3'b111) e_result = m_alu;
    else                     e_result = ref_load(m_op, int'(m_alu[1:0]), m_have ? m_data : rdata);
  endtask

  task automatic model_update();
    if (data_ok && m_orph > 0) m_orph--;
    if (ms_flush) begin
      if (m_valid && m_mem && !m_have && !e_mine) m_orph++;
      m_valid = 0; m_have = 0;
    end else if (e_valid && ws_allowin) begin
      m_valid = 0; m_have = 0;
    end else if (m_valid && m_mem && !m_have && e_mine) begin
      m_have = 1; m_data = rdata;
    end
    if (!ms_flush && e_allowin && es_to_ms_valid) begin
      m_valid = 1;
      {m_mem, m_op, m_we, m_dest, m_alu, m_pc} = es_bus;
    end
  endtask

  task automatic tick();
    model_eval();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    es_to_ms_valid = 0; es_bus = '0; ws_allowin = 1; data_ok = 0; rdata = '0; ms_flush = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ms_to_ws_valid); end
    checks++; if (ws_bus !== '0) begin errors++; $display("FAIL rst_bus got=%h exp=0", ws_bus); end
    checks++; if ({fwd_we, fwd_dest, fwd_data, fwd_stall} !== '0) begin errors++; $display("FAIL rst_fwd got=%b/%h/%h/%b exp=0", fwd_we, fwd_dest, fwd_data, fwd_stall); end
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got=%b exp=1", ms_allowin); end
  endtask

  task automatic test_ld_b_same_cycle();
    apply_reset();
    es_to_ms_valid = 1; es_bus = mk_bus(1, LD_B, 1, 5'd5, 32'h0000_1003, 32'h100); tick();
    es_to_ms_valid = 0; #1;
    checks++; if (fwd_stall !== 1'b1 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ldb_wait got stall=%b valid=%b exp stall=1 valid=0", fwd_stall, ms_to_ws_valid); end
    data_ok = 1; rdata = 32'h80AB_CDEF; #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got=%b exp=1", ms_to_ws_valid); end
    checks++; if (out_res !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_result got=%h exp=ffffff80", out_res); end
    checks++; if (fwd_stall !== 1'b0 || out_pc !== 32'h100) begin errors++; $display("FAIL ldb_stall_pc got stall=%b pc=%h exp stall=0 pc=100", fwd_stall, out_pc); end
    tick();
    data_ok = 0; #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ldb_one_cycle got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_ld_hu_buffered();
    apply_reset();
    es_to_ms_valid = 1; es_bus = mk_bus(1, LD_HU, 1, 5'd6, 32'h0000_2002, 32'h200); tick();
    es_to_ms_valid = 0;
    for (int c = 0; c < 4; c++) begin
      ws_allowin = (c == 3); data_ok = (c == 0); rdata = (c == 0) ? 32'hBEEF_1234 : 32'h0; #1;
      checks++; if (ms_to_ws_valid !== 1'b1 || out_res !== 32'h0000_BEEF) begin errors++; $display("FAIL ldhu_hold%0d got valid=%b res=%h exp valid=1 res=0000beef", c, ms_to_ws_valid, out_res); end
      checks++; if (ms_allowin !== (c == 3)) begin errors++; $display("FAIL ldhu_allowin%0d got=%b exp=%b", c, ms_allowin, c == 3); end
      tick();
    end
    data_ok = 0; #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ldhu_gone got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_orphan();
    apply_reset();
    es_to_ms_valid = 1; es_bus = mk_bus(1, LD_W, 1, 5'd3, 32'h30, 32'h300); tick();
    es_to_ms_valid = 0; ms_flush = 1; #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL orph_flush got=%b exp=0", ms_to_ws_valid); end
    tick();
    ms_flush = 0; es_to_ms_valid = 1; es_bus = mk_bus(1, LD_W, 1, 5'd4, 32'h34, 32'h304); tick();
    es_to_ms_valid = 0; data_ok = 1; rdata = 32'hDEAD_BEEF; #1;
    checks++; if (ms_to_ws_valid !== 1'b0 || fwd_stall !== 1'b1) begin errors++; $display("FAIL orph_drop got valid=%b stall=%b exp valid=0 stall=1", ms_to_ws_valid, fwd_stall); end
    tick();
    rdata = 32'h1234_5678; #1;
    checks++; if (ms_to_ws_valid !== 1'b1 || out_res !== 32'h1234_5678 || out_pc !== 32'h304) begin errors++; $display("FAIL orph_next got valid=%b res=%h pc=%h exp 1/12345678/304", ms_to_ws_valid, out_res, out_pc); end
    tick();
    data_ok = 0;
  endtask

  task automatic test_flush_same_cycle();
    apply_reset();
    es_to_ms_valid = 1; es_bus = mk_bus(1, LD_W, 1, 5'd9, 32'h40, 32'h400); tick();
    es_to_ms_valid = 0; ms_flush = 1; data_ok = 1; rdata = 32'hAAAA_AAAA; #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flsame_valid got=%b exp=0", ms_to_ws_valid); end
    tick();
    ms_flush = 0; data_ok = 0; es_to_ms_valid = 1; es_bus = mk_bus(1, LD_W, 1, 5'd10, 32'h44, 32'h404); tick();
    es_to_ms_valid = 0; data_ok = 1; rdata = 32'hCAFE_F00D; #1;
    checks++; if (ms_to_ws_valid !== 1'b1 || out_res !== 32'hCAFE_F00D) begin errors++; $display("FAIL flsame_next got valid=%b res=%h exp 1/cafef00d", ms_to_ws_valid, out_res); end
    tick();
    data_ok = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [5] = '{32'h500, 32'h0, 32'h0, 32'h504, 32'h508};
    logic [31:0] exp_res [5] = '{32'h11, 32'h0, 32'h0, 32'h55AA_33CC, 32'h33};
    logic        exp_vld [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_stl [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    es_to_ms_valid = 1; es_bus = mk_bus(0, LD_NONE, 1, 5'd1, 32'h11, 32'h500); tick();
    for (int c = 0; c < 5; c++) begin
      es_to_ms_valid = (c < 4);
      es_bus = (c == 0) ? mk_bus(1, LD_W, 1, 5'd2, 32'h20, 32'h504) : mk_bus(0, LD_NONE, 1, 5'd3, 32'h33, 32'h508);
      data_ok = (c == 3); rdata = (c == 3) ? 32'h55AA_33CC : 32'h0; #1;
      checks++; if (ms_to_ws_valid !== exp_vld[c] || fwd_stall !== exp_stl[c]) begin errors++; $display("FAIL b2b_ctl%0d got valid=%b stall=%b exp valid=%b stall=%b", c, ms_to_ws_valid, fwd_stall, exp_vld[c], exp_stl[c]); end
      if (exp_vld[c]) begin
        checks++; if (out_pc !== exp_pc[c] || out_res !== exp_res[c]) begin errors++; $display("FAIL b2b_data%0d got pc=%h res=%h exp pc=%h res=%h", c, out_pc, out_res, exp_pc[c], exp_res[c]); end
      end
      tick();
    end
    data_ok = 0; es_to_ms_valid = 0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    es_to_ms_valid = 1; es_bus = mk_bus(1, LD_W, 1, 5'd7, 32'h60, 32'h600); tick();
    es_to_ms_valid = 0; ws_allowin = 0; data_ok = 1; rdata = 32'h1357_9BDF; tick();
    data_ok = 0; rdata = '0; #1;
    checks++; if (ms_to_ws_valid !== 1'b1 || out_res !== 32'h1357_9BDF) begin errors++; $display("FAIL arst_pre got valid=%b res=%h exp 1/13579bdf", ms_to_ws_valid, out_res); end
    reset = 1; #1;
    model_reset();
    checks++; if (ms_to_ws_valid !== 1'b0 || ws_bus !== '0) begin errors++; $display("FAIL arst_out got valid=%b bus=%h exp 0/0", ms_to_ws_valid, ws_bus); end
    checks++; if ({fwd_we, fwd_dest, fwd_data, fwd_stall} !== '0) begin errors++; $display("FAIL arst_fwd got=%b/%h/%h/%b exp=0", fwd_we, fwd_dest, fwd_data, fwd_stall); end
    @(posedge clk); @(negedge clk);
    reset = 0; ws_allowin = 1;
    es_to_ms_valid = 1; es_bus = mk_bus(1, LD_W, 1, 5'd8, 32'h64, 32'h700); tick();
    es_to_ms_valid = 0; #1;
    checks++; if (ms_to_ws_valid !== 1'b0 || fwd_stall !== 1'b1) begin errors++; $display("FAIL arst_stale got valid=%b stall=%b exp 0/1", ms_to_ws_valid, fwd_stall); end
    data_ok = 1; rdata = 32'h2468_ACE0; #1;
    checks++; if (ms_to_ws_valid !== 1'b1 || out_res !== 32'h2468_ACE0) begin errors++; $display("FAIL arst_after got valid=%b res=%h exp 1/2468ace0", ms_to_ws_valid, out_res); end
    tick();
    data_ok = 0;
  endtask

  task automatic test_random();
    logic [2:0] ops [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      int         outst;
      logic       mem;
      logic [2:0] op;
      outst          = m_orph + ((m_valid && m_mem && !m_have) ? 1 : 0);
      ws_allowin     = ($urandom_range(0, 3) != 0);
      data_ok        = (outst > 0) && ($urandom_range(0, 2) == 0);
      rdata          = $urandom;
      ms_flush       = m_valid && (m_orph < MAX_DISC_DEF) && ($urandom_range(0, 9) == 0);
      es_to_ms_valid = $urandom_range(0, 1);
      mem            = 1'($urandom_range(0, 1));
      op             = mem ? ops[$urandom_range(0, 5)] : 3'b111;
      es_bus         = mk_bus(mem, op, 1'($urandom), 5'($urandom), $urandom, $urandom);
      #1;
      model_eval();
      checks++; if (ms_to_ws_valid !== e_valid || ms_allowin !== e_allowin) begin errors++; $display("FAIL rnd_hs c=%0d got valid=%b allowin=%b exp valid=%b allowin=%b", c, ms_to_ws_valid, ms_allowin, e_valid, e_allowin); end
      checks++; if (fwd_stall !== e_stall || fwd_we !== (m_valid && m_we) || fwd_dest !== (m_valid ? m_dest : 5'd0)) begin errors++; $display("FAIL rnd_fwd c=%0d got stall=%b we=%b dest=%0d exp stall=%b we=%b dest=%0d", c, fwd_stall, fwd_we, fwd_dest, e_stall, m_valid && m_we, m_valid ? m_dest : 5'd0); end
      checks++; if (fwd_data !== e_result) begin errors++; $display("FAIL rnd_fwd_data c=%0d got=%h exp=%h", c, fwd_data, e_result); end
      if (e_valid) begin
        checks++; if (ws_bus !== {m_we, m_dest, e_result, m_pc}) begin errors++; $display("FAIL rnd_bus c=%0d got=%h exp=%h", c, ws_bus, {m_we, m_dest, e_result, m_pc}); end
      end
      tick();
    end
    es_to_ms_valid = 0; data_ok = 0; ms_flush = 0;
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_ld_b_same_cycle();
    test_ld_hu_buffered();
    test_flush_orphan();
    test_flush_same_cycle();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
